// File: rtl/lut_ram_arbiter.sv
// rtl/lut_ram_arbiter.sv - shared 256x8 activation LUT with round-robin whole-batch read arbitration.
// Optional forced-release timeout enabled by defining LUT_ARB_TIMEOUT_EN.
module lut_ram_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic [NUM_REQ*8-1:0] x_req,
    output logic [7:0]           y_o,
    input  logic                 cfg_valid,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_data,
    output logic                 cfg_ready,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("lut_ram_arbiter: NUM_REQ and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state, state_d;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [LW-1:0]        last, last_d;
    logic                 busy_d;
    logic                 terr_d;
    logic                 wr_en;
    logic                 pick_found;
    logic [LW-1:0]        pick_idx;
    logic                 timeout_hit;
    logic [7:0]           x_sel;
    logic [7:0]           lut [256];

`ifdef LUT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == OWN) && req[last] && (hold_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin search starts just after the previous owner and wraps.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int cand;
            cand = (int'(last) + i) % NUM_REQ;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = LW'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        last_d    = last;
        busy_d    = busy;
        terr_d    = 1'b0;
        wr_en     = 1'b0;
        cfg_ready = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = cfg_valid;
                if (cfg_valid) begin
                    wr_en = 1'b1;
                end else if (pick_found) begin
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    last_d  = pick_idx;
                    busy_d  = 1'b1;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!req[last] || timeout_hit) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    terr_d  = timeout_hit;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            last        <= LW'(NUM_REQ - 1);
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            gnt         <= gnt_d;
            last        <= last_d;
            busy        <= busy_d;
            timeout_err <= terr_d;
        end
    end

    // While busy, last always names the current owner.
    assign x_sel = busy ? x_req[int'(last)*8 +: 8] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_o <= 8'h00;
            for (int i = 0; i < 256; i++) begin
                lut[i] <= 8'(i);
            end
        end else begin
            y_o <= lut[x_sel];
            if (wr_en) begin
                lut[cfg_addr] <= cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_lut_ram_arbiter.sv
// tb/tb_lut_ram_arbiter.sv - randomized and directed self-checking bench for lut_ram_arbiter.
module tb_lut_ram_arbiter;

    localparam int NR = 2;
    localparam int TO = 8;
`ifdef LUT_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   gnt;
    logic [NR*8-1:0] x_req = '0;
    logic [7:0]      y_o;
    logic            cfg_valid = 1'b0;
    logic [7:0]      cfg_addr = '0;
    logic [7:0]      cfg_data = '0;
    logic            cfg_ready;
    logic            busy;
    logic            timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: table contents, current owner (-1 = none), last owner.
    logic [7:0] m_mem [256];
    int         m_owner;
    int         m_last;
    int         m_hold;
    logic [7:0] m_y;
    logic       m_terr;

    logic [NR-1:0] rr;
    int            first_owner;
    int            waited;
    int            hi;

    lut_ram_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .x_req(x_req), .y_o(y_o),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'(i);
        m_owner = -1;
        m_last  = NR - 1;
        m_hold  = 0;
        m_y     = 8'h00;
        m_terr  = 1'b0;
    endtask

    task automatic model_edge();
        int         sel;
        logic [7:0] ny;
        sel    = (m_owner >= 0) ? int'(x_req[m_owner*8 +: 8]) : 0;
        ny     = m_mem[sel];
        m_terr = 1'b0;
        if (m_owner < 0) begin
            if (cfg_valid) begin
                m_mem[cfg_addr] = cfg_data;
            end else if (req != 0) begin
                for (int i = 1; i <= NR; i++) begin
                    if (m_owner < 0 && req[(m_last + i) % NR]) m_owner = (m_last + i) % NR;
                end
                m_last = m_owner;
                m_hold = 0;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_hold == TO - 1) begin
            m_owner = -1;
            m_terr  = 1'b1;
        end else begin
            m_hold++;
        end
        m_y = ny;
    endtask

    task automatic compare_all();
        check("gnt", gnt, (m_owner < 0) ? 0 : (1 << m_owner));
        check("busy", busy, m_owner >= 0);
        check("y_o", y_o, m_y);
        check("timeout_err", timeout_err, m_terr);
        check("onehot", $countones(gnt) <= 1, 1);
    endtask

    // Called at a falling edge: drive, check combinational ready, clock once, compare.
    task automatic step(input logic [NR-1:0] r, input logic [NR*8-1:0] x,
                        input logic cv, input logic [7:0] ca, input logic [7:0] cd);
        req = r; x_req = x; cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
        #1;
        check("cfg_ready", cfg_ready, cv && (m_owner < 0));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // Idle lookups read entry 0 regardless of requester addresses.
        step(2'b00, 16'h0037, 1'b0, 8'h00, 8'h00);
        check("idle_y", y_o, 8'h00);
        step(2'b00, 16'h0037, 1'b0, 8'h00, 8'h00);

        // Config writes, then a batch reads them back.
        step(2'b00, 16'h0000, 1'b1, 8'h10, 8'hA5);
        step(2'b00, 16'h0000, 1'b1, 8'h11, 8'h5A);
        step(2'b01, 16'h0000, 1'b0, 8'h00, 8'h00);
        check("gnt0_rise", gnt, 2'b01);
        step(2'b01, 16'h0010, 1'b0, 8'h00, 8'h00);
        check("y_a5", y_o, 8'hA5);
        step(2'b01, 16'h0011, 1'b0, 8'h00, 8'h00);
        check("y_5a", y_o, 8'h5A);
        step(2'b01, 16'h0012, 1'b0, 8'h00, 8'h00);
        check("y_12", y_o, 8'h12);
        step(2'b00, 16'h0000, 1'b0, 8'h00, 8'h00);
        check("gnt_drop", gnt, 2'b00);

        // Contention from a fresh pointer: 0,1,0,1 with one idle cycle between grants.
        pulse_reset();
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (gnt == 0 && waited < 8) begin
                step(2'b11, 16'($urandom), 1'b0, 8'h00, 8'h00);
                waited++;
            end
            check("rr_order", gnt, 2'b01 << (g % 2));
            check("rr_gap", waited, 1);
            repeat (3) step(2'b11, 16'($urandom), 1'b0, 8'h00, 8'h00);
            step(2'b11 & ~gnt, 16'h0000, 1'b0, 8'h00, 8'h00);
        end

        // Config held off while unit 1 owns the table.
        step(2'b10, 16'h0000, 1'b0, 8'h00, 8'h00);
        check("gnt1", gnt, 2'b10);
        repeat (2) step(2'b11, 16'h4000, 1'b1, 8'h40, 8'h99);
        step(2'b01, 16'h4000, 1'b1, 8'h40, 8'h99);
        step(2'b01, 16'h0000, 1'b1, 8'h40, 8'h99);
        check("cfg_in_idle_gnt", gnt, 2'b00);
        step(2'b01, 16'h0040, 1'b0, 8'h00, 8'h00);
        check("gnt0_after_cfg", gnt, 2'b01);
        step(2'b01, 16'h0040, 1'b0, 8'h00, 8'h00);
        check("y_99", y_o, 8'h99);
        step(2'b00, 16'h0000, 1'b0, 8'h00, 8'h00);

        // Reset mid-batch restores the identity table.
        step(2'b00, 16'h0000, 1'b1, 8'h20, 8'hFF);
        step(2'b01, 16'h0020, 1'b0, 8'h00, 8'h00);
        step(2'b01, 16'h0020, 1'b0, 8'h00, 8'h00);
        check("y_ff", y_o, 8'hFF);
        pulse_reset();
        step(2'b01, 16'h0020, 1'b0, 8'h00, 8'h00);
        step(2'b01, 16'h0020, 1'b0, 8'h00, 8'h00);
        check("y_identity", y_o, 8'h20);
        step(2'b00, 16'h0000, 1'b0, 8'h00, 8'h00);

`ifdef LUT_ARB_TIMEOUT_EN
        pulse_reset();
        step(2'b11, 16'h0000, 1'b0, 8'h00, 8'h00);
        hi = (gnt == 2'b01) ? 1 : 0;
        while (gnt == 2'b01 && hi < 20) begin
            step(2'b11, 16'($urandom), 1'b0, 8'h00, 8'h00);
            if (gnt == 2'b01) hi++;
        end
        check("to_hold_cycles", hi, TO);
        check("to_pulse", timeout_err, 1);
        step(2'b11, 16'h0000, 1'b0, 8'h00, 8'h00);
        check("to_next_owner", gnt, 2'b10);
        step(2'b00, 16'h0000, 1'b0, 8'h00, 8'h00);
        step(2'b00, 16'h0000, 1'b0, 8'h00, 8'h00);
`endif

        // Randomized traffic against the reference model.
        first_owner = 0;
        rr = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) rr = NR'($urandom);
            step(rr, 16'($urandom), ($urandom_range(5) == 0), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
